// File: rtl/ooo_reorder_buffer_pkg.sv
`default_nettype none
// ooo_reorder_buffer_pkg: shared widths, ROB tag types and the dispatch/result/commit/entry records.
// Rev 1.0
package ooo_reorder_buffer_pkg;

  localparam int ROB_SIZE       = 8;
  localparam int DATA_WIDTH     = 32;
  localparam int PC_WIDTH       = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int CAUSE_WIDTH    = 4;
  localparam int ROB_ADDR_WIDTH = $clog2(ROB_SIZE);
  localparam int ROB_CNT_WIDTH  = ROB_ADDR_WIDTH + 1;

  typedef logic [ROB_ADDR_WIDTH-1:0] rob_tag_t;
  typedef logic [ROB_CNT_WIDTH-1:0]  rob_cnt_t;

  typedef struct packed {
    logic                      valid;
    rob_tag_t                  rob_tag;
    logic [PC_WIDTH-1:0]       pc;
    logic [REG_ADDR_WIDTH-1:0] rd_addr;
    logic                      rd_write_en;
  } ooo_dispatch_t;

  typedef struct packed {
    logic                   valid;
    rob_tag_t               rob_tag;
    logic [DATA_WIDTH-1:0]  data;
    logic                   exception_valid;
    logic [CAUSE_WIDTH-1:0] exception_cause;
  } ooo_result_t;

  typedef struct packed {
    logic                      valid;
    rob_tag_t                  rob_tag;
    logic [PC_WIDTH-1:0]       pc;
    logic [REG_ADDR_WIDTH-1:0] rd_addr;
    logic                      rd_write_en;
    logic [DATA_WIDTH-1:0]     result;
    logic                      exception_valid;
    logic [CAUSE_WIDTH-1:0]    exception_cause;
  } ooo_commit_t;

  typedef struct packed {
    logic                      valid;
    logic                      done;
    logic [PC_WIDTH-1:0]       pc;
    logic [REG_ADDR_WIDTH-1:0] rd_addr;
    logic                      rd_write_en;
    logic [DATA_WIDTH-1:0]     data;
    logic                      exception_valid;
    logic [CAUSE_WIDTH-1:0]    exception_cause;
  } rob_entry_t;

  // ROB_SIZE is a power of two, so natural overflow of the tag is the wrap.
  function automatic rob_tag_t rob_next(input rob_tag_t ptr);
    return ptr + 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ooo_reorder_buffer_if.sv
`default_nettype none
// ooo_reorder_buffer_if: dispatch, writeback, operand lookup and commit signals of the ROB.
// Rev 1.0
interface ooo_reorder_buffer_if;
  import ooo_reorder_buffer_pkg::*;

  ooo_dispatch_t                    dispatch_i;
  logic                             dispatch_ready_o;
  rob_tag_t                         alloc_tag_o;
  ooo_result_t                      result_i;
  rob_tag_t [1:0]                   lookup_tag_i;
  logic [1:0]                       lookup_ready_o;
  logic [1:0][DATA_WIDTH-1:0]       lookup_data_o;
  ooo_commit_t                      commit_o;
  logic                             commit_ready_i;
  logic                             flush_i;
  logic                             flush_o;
  rob_cnt_t                         count_o;

  modport master (
    output dispatch_i, result_i, lookup_tag_i, commit_ready_i, flush_i,
    input  dispatch_ready_o, alloc_tag_o, lookup_ready_o, lookup_data_o,
           commit_o, flush_o, count_o
  );

  modport slave (
    input  dispatch_i, result_i, lookup_tag_i, commit_ready_i, flush_i,
    output dispatch_ready_o, alloc_tag_o, lookup_ready_o, lookup_data_o,
           commit_o, flush_o, count_o
  );

endinterface
`default_nettype wire

// File: rtl/ooo_rob_lookup.sv
`default_nettype none
// ooo_rob_lookup: operand read of one ROB entry with same-cycle CDB bypass.
// Rev 1.0
module ooo_rob_lookup
  import ooo_reorder_buffer_pkg::*;
(
  input  rob_tag_t              tag,
  input  logic                  entry_valid,
  input  logic                  entry_done,
  input  logic [DATA_WIDTH-1:0] entry_data,
  input  logic                  result_valid,
  input  rob_tag_t              result_tag,
  input  logic [DATA_WIDTH-1:0] result_data,
  output logic                  ready,
  output logic [DATA_WIDTH-1:0] data
);

  // A writeback to an unallocated entry is dropped by the ROB, so it must not bypass either.
  always_comb begin
    ready = 1'b0;
    data  = '0;
    if (entry_valid) begin
      if (result_valid && (result_tag == tag)) begin
        ready = 1'b1;
        data  = result_data;
      end else if (entry_done) begin
        ready = 1'b1;
        data  = entry_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ooo_reorder_buffer.sv
`default_nettype none
// ooo_reorder_buffer: circular re-order buffer; allocates tags, collects writebacks, commits in order.
// Rev 1.0
module ooo_reorder_buffer
  import ooo_reorder_buffer_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  ooo_reorder_buffer_if.slave  rob
);

  rob_entry_t entries [ROB_SIZE];
  rob_tag_t   head;
  rob_tag_t   tail;
  rob_cnt_t   count;
  logic       flush_q;

  rob_entry_t head_entry;
  logic       commit_valid;
  logic       commit_fire;
  logic       exc_fire;
  logic       dispatch_fire;
  logic       result_hit;
  logic       unused_dispatch_tag;

  assign head_entry    = entries[head];
  // Gated by rst_i so nothing retires while the ROB is being reset.
  assign commit_valid  = head_entry.valid & head_entry.done & ~rst_i;
  assign commit_fire   = commit_valid & rob.commit_ready_i;
  assign exc_fire      = commit_fire & head_entry.exception_valid;
  assign dispatch_fire = rob.dispatch_i.valid & rob.dispatch_ready_o;
  assign result_hit    = rob.result_i.valid & entries[rob.result_i.rob_tag].valid;

  assign rob.dispatch_ready_o = (count != rob_cnt_t'(ROB_SIZE));
  assign rob.alloc_tag_o      = tail;
  assign rob.count_o          = count;
  assign rob.flush_o          = flush_q;
  assign unused_dispatch_tag  = ^rob.dispatch_i.rob_tag;

  always_comb begin
    rob.commit_o = '0;
    if (commit_valid) begin
      rob.commit_o.valid           = 1'b1;
      rob.commit_o.rob_tag         = head;
      rob.commit_o.pc              = head_entry.pc;
      rob.commit_o.rd_addr         = head_entry.rd_addr;
      rob.commit_o.rd_write_en     = head_entry.rd_write_en;
      rob.commit_o.result          = head_entry.data;
      rob.commit_o.exception_valid = head_entry.exception_valid;
      rob.commit_o.exception_cause = head_entry.exception_cause;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < ROB_SIZE; i++) begin
        entries[i] <= '0;
      end
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      flush_q <= 1'b0;
    end else begin
      flush_q <= exc_fire & ~rob.flush_i;
      if (rob.flush_i || exc_fire) begin
        for (int i = 0; i < ROB_SIZE; i++) begin
          entries[i].valid <= 1'b0;
          entries[i].done  <= 1'b0;
        end
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (result_hit) begin
          entries[rob.result_i.rob_tag].data            <= rob.result_i.data;
          entries[rob.result_i.rob_tag].exception_valid <= rob.result_i.exception_valid;
          entries[rob.result_i.rob_tag].exception_cause <= rob.result_i.exception_cause;
          entries[rob.result_i.rob_tag].done            <= 1'b1;
        end
        if (commit_fire) begin
          entries[head].valid <= 1'b0;
          entries[head].done  <= 1'b0;
          head                <= rob_next(head);
        end
        // Not full means tail never aliases a live head entry.
        if (dispatch_fire) begin
          entries[tail].valid           <= 1'b1;
          entries[tail].done            <= 1'b0;
          entries[tail].pc              <= rob.dispatch_i.pc;
          entries[tail].rd_addr         <= rob.dispatch_i.rd_addr;
          entries[tail].rd_write_en     <= rob.dispatch_i.rd_write_en;
          entries[tail].data            <= '0;
          entries[tail].exception_valid <= 1'b0;
          entries[tail].exception_cause <= '0;
          tail                          <= rob_next(tail);
        end
        case ({dispatch_fire, commit_fire})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  for (genvar k = 0; k < 2; k++) begin : g_lookup
    ooo_rob_lookup u_lookup (
      .tag          (rob.lookup_tag_i[k]),
      .entry_valid  (entries[rob.lookup_tag_i[k]].valid),
      .entry_done   (entries[rob.lookup_tag_i[k]].done),
      .entry_data   (entries[rob.lookup_tag_i[k]].data),
      .result_valid (rob.result_i.valid),
      .result_tag   (rob.result_i.rob_tag),
      .result_data  (rob.result_i.data),
      .ready        (rob.lookup_ready_o[k]),
      .data         (rob.lookup_data_o[k])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_ooo_reorder_buffer.sv
`default_nettype none
// tb_ooo_reorder_buffer: directed scenarios for the re-order buffer with ROB_SIZE=8.
module tb_ooo_reorder_buffer;
  import ooo_reorder_buffer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests_run    = 0;
  int   tests_failed = 0;

  ooo_reorder_buffer_if rif ();

  ooo_reorder_buffer dut (
    .clk_i (clk),
    .rst_i (rst),
    .rob   (rif)
  );

  always #5 clk = ~clk;

  // Every accepted dispatch must carry the tag the ROB is about to allocate.
  always @(posedge clk) begin
    if (!rst && rif.dispatch_i.valid && rif.dispatch_ready_o &&
        (rif.dispatch_i.rob_tag !== rif.alloc_tag_o)) begin
      tests_run++;
      tests_failed++;
      $display("FAIL dispatch_tag: got %0d expected %0d", rif.dispatch_i.rob_tag, rif.alloc_tag_o);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [PC_WIDTH-1:0] pc_of(input rob_tag_t t);
    return PC_WIDTH'(32'h1000 + 4 * int'(t));
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rif.dispatch_i     = '0;
    rif.result_i       = '0;
    rif.commit_ready_i = 1'b0;
    rif.flush_i        = 1'b0;
  endtask

  task automatic set_dispatch(input rob_tag_t tag);
    rif.dispatch_i.valid       = 1'b1;
    rif.dispatch_i.rob_tag     = tag;
    rif.dispatch_i.pc          = pc_of(tag);
    rif.dispatch_i.rd_addr     = REG_ADDR_WIDTH'(int'(tag) + 1);
    rif.dispatch_i.rd_write_en = 1'b1;
  endtask

  task automatic set_result(input rob_tag_t tag, input logic [DATA_WIDTH-1:0] d,
                            input logic exc, input logic [CAUSE_WIDTH-1:0] cause);
    rif.result_i.valid           = 1'b1;
    rif.result_i.rob_tag         = tag;
    rif.result_i.data            = d;
    rif.result_i.exception_valid = exc;
    rif.result_i.exception_cause = cause;
  endtask

  task automatic test_reset();
    idle_inputs();
    rif.lookup_tag_i = '0;
    rst = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    tests_run++; if (rif.dispatch_ready_o !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b expected 1", rif.dispatch_ready_o); end
    tests_run++; if (rif.alloc_tag_o !== 3'd0) begin tests_failed++; $display("FAIL reset_alloc_tag: got %0d expected 0", rif.alloc_tag_o); end
    tests_run++; if (rif.commit_o !== '0) begin tests_failed++; $display("FAIL reset_commit: got %h expected 0", rif.commit_o); end
    tests_run++; if (rif.flush_o !== 1'b0) begin tests_failed++; $display("FAIL reset_flush: got %b expected 0", rif.flush_o); end
    tests_run++; if (rif.count_o !== 4'd0) begin tests_failed++; $display("FAIL reset_count: got %0d expected 0", rif.count_o); end
    tests_run++; if (rif.lookup_ready_o !== 2'b00) begin tests_failed++; $display("FAIL reset_lookup_ready: got %b expected 00", rif.lookup_ready_o); end
    next_cycle();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      set_dispatch(rob_tag_t'(i));
      @(negedge clk);
      tests_run++; if (rif.alloc_tag_o !== rob_tag_t'(i)) begin tests_failed++; $display("FAIL fill_alloc_tag: got %0d expected %0d", rif.alloc_tag_o, i); end
      tests_run++; if (rif.dispatch_ready_o !== 1'b1) begin tests_failed++; $display("FAIL fill_ready: got %b expected 1 at %0d", rif.dispatch_ready_o, i); end
      next_cycle();
    end
    idle_inputs();
    @(negedge clk);
    tests_run++; if (rif.count_o !== 4'd8) begin tests_failed++; $display("FAIL fill_count: got %0d expected 8", rif.count_o); end
    tests_run++; if (rif.dispatch_ready_o !== 1'b0) begin tests_failed++; $display("FAIL fill_full_ready: got %b expected 0", rif.dispatch_ready_o); end
    set_dispatch(3'd0);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    tests_run++; if (rif.count_o !== 4'd8) begin tests_failed++; $display("FAIL fill_ninth_count: got %0d expected 8", rif.count_o); end
    tests_run++; if (rif.alloc_tag_o !== 3'd0) begin tests_failed++; $display("FAIL fill_ninth_tail: got %0d expected 0", rif.alloc_tag_o); end
    next_cycle();
  endtask

  task automatic test_ooo_completion();
    logic [DATA_WIDTH-1:0] exp_data [3];
    exp_data[0] = 32'h00; exp_data[1] = 32'h11; exp_data[2] = 32'h22;
    set_result(3'd2, 32'h22, 1'b0, '0);
    @(negedge clk);
    tests_run++; if (rif.commit_o.valid !== 1'b0) begin tests_failed++; $display("FAIL ooo_early_commit: got %b expected 0", rif.commit_o.valid); end
    next_cycle();
    set_result(3'd1, 32'h11, 1'b0, '0);
    next_cycle();
    set_result(3'd0, 32'h00, 1'b0, '0);
    @(negedge clk);
    tests_run++; if (rif.commit_o.valid !== 1'b0) begin tests_failed++; $display("FAIL ooo_result_latency: got %b expected 0", rif.commit_o.valid); end
    next_cycle();
    idle_inputs();
    rif.commit_ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests_run++; if (rif.commit_o.valid !== 1'b1) begin tests_failed++; $display("FAIL ooo_commit_valid: got %b expected 1 at %0d", rif.commit_o.valid, k); end
      tests_run++; if (rif.commit_o.rob_tag !== rob_tag_t'(k)) begin tests_failed++; $display("FAIL ooo_commit_tag: got %0d expected %0d", rif.commit_o.rob_tag, k); end
      tests_run++; if (rif.commit_o.result !== exp_data[k]) begin tests_failed++; $display("FAIL ooo_commit_data: got %h expected %h", rif.commit_o.result, exp_data[k]); end
      tests_run++; if (rif.commit_o.pc !== pc_of(rob_tag_t'(k))) begin tests_failed++; $display("FAIL ooo_commit_pc: got %h expected %h", rif.commit_o.pc, pc_of(rob_tag_t'(k))); end
      next_cycle();
    end
    rif.commit_ready_i = 1'b0;
    @(negedge clk);
    tests_run++; if (rif.commit_o.valid !== 1'b0) begin tests_failed++; $display("FAIL ooo_head3_not_done: got %b expected 0", rif.commit_o.valid); end
    tests_run++; if (rif.count_o !== 4'd5) begin tests_failed++; $display("FAIL ooo_count: got %0d expected 5", rif.count_o); end
    next_cycle();
  endtask

  task automatic test_backpressure();
    set_result(3'd3, 32'h33, 1'b0, '0);
    next_cycle();
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests_run++; if (rif.commit_o.valid !== 1'b1) begin tests_failed++; $display("FAIL bp_valid: got %b expected 1 at %0d", rif.commit_o.valid, k); end
      tests_run++; if (rif.commit_o.rob_tag !== 3'd3) begin tests_failed++; $display("FAIL bp_tag: got %0d expected 3", rif.commit_o.rob_tag); end
      tests_run++; if (rif.commit_o.result !== 32'h33) begin tests_failed++; $display("FAIL bp_data: got %h expected 33", rif.commit_o.result); end
      tests_run++; if (rif.count_o !== 4'd5) begin tests_failed++; $display("FAIL bp_count: got %0d expected 5", rif.count_o); end
      next_cycle();
    end
    rif.commit_ready_i = 1'b1;
    @(negedge clk);
    tests_run++; if (rif.commit_o.valid !== 1'b1) begin tests_failed++; $display("FAIL bp_release_valid: got %b expected 1", rif.commit_o.valid); end
    next_cycle();
    rif.commit_ready_i = 1'b0;
    @(negedge clk);
    tests_run++; if (rif.count_o !== 4'd4) begin tests_failed++; $display("FAIL bp_retired_count: got %0d expected 4", rif.count_o); end
    tests_run++; if (rif.commit_o.valid !== 1'b0) begin tests_failed++; $display("FAIL bp_next_head: got %b expected 0", rif.commit_o.valid); end
    next_cycle();
  endtask

  task automatic test_wrap();
    rob_tag_t tag;
    rif.flush_i = 1'b1;
    next_cycle();
    idle_inputs();
    @(negedge clk);
    tests_run++; if (rif.count_o !== 4'd0) begin tests_failed++; $display("FAIL wrap_flush_count: got %0d expected 0", rif.count_o); end
    tests_run++; if (rif.flush_o !== 1'b0) begin tests_failed++; $display("FAIL wrap_flush_o: got %b expected 0", rif.flush_o); end
    next_cycle();
    for (int i = 0; i < 12; i++) begin
      tag = rob_tag_t'(i % 8);
      set_dispatch(tag);
      @(negedge clk);
      tests_run++; if (rif.alloc_tag_o !== tag) begin tests_failed++; $display("FAIL wrap_alloc_tag: got %0d expected %0d", rif.alloc_tag_o, tag); end
      next_cycle();
      idle_inputs();
      set_result(tag, DATA_WIDTH'(32'h500 + i), 1'b0, '0);
      next_cycle();
      idle_inputs();
      rif.commit_ready_i = 1'b1;
      @(negedge clk);
      tests_run++; if ((rif.commit_o.valid !== 1'b1) || (rif.commit_o.rob_tag !== tag)) begin tests_failed++; $display("FAIL wrap_commit: got valid=%b tag=%0d expected valid=1 tag=%0d", rif.commit_o.valid, rif.commit_o.rob_tag, tag); end
      tests_run++; if (rif.count_o !== 4'd1) begin tests_failed++; $display("FAIL wrap_count_busy: got %0d expected 1", rif.count_o); end
      next_cycle();
      idle_inputs();
      @(negedge clk);
      tests_run++; if (rif.count_o !== 4'd0) begin tests_failed++; $display("FAIL wrap_count_empty: got %0d expected 0", rif.count_o); end
      next_cycle();
    end
    set_dispatch(3'd4);
    next_cycle();
    idle_inputs();
    set_result(3'd4, 32'h777, 1'b0, '0);
    next_cycle();
    idle_inputs();
    rif.commit_ready_i = 1'b1;
    set_dispatch(3'd5);
    @(negedge clk);
    tests_run++; if ((rif.commit_o.valid !== 1'b1) || (rif.commit_o.rob_tag !== 3'd4)) begin tests_failed++; $display("FAIL wrap_pair_commit: got valid=%b tag=%0d expected valid=1 tag=4", rif.commit_o.valid, rif.commit_o.rob_tag); end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    tests_run++; if (rif.count_o !== 4'd1) begin tests_failed++; $display("FAIL wrap_pair_count: got %0d expected 1", rif.count_o); end
    tests_run++; if (rif.alloc_tag_o !== 3'd6) begin tests_failed++; $display("FAIL wrap_pair_tail: got %0d expected 6", rif.alloc_tag_o); end
    next_cycle();
  endtask

  task automatic test_exception();
    rif.flush_i = 1'b1;
    next_cycle();
    idle_inputs();
    for (int i = 0; i < 6; i++) begin
      set_dispatch(rob_tag_t'(i));
      next_cycle();
    end
    idle_inputs();
    for (int i = 0; i < 6; i++) begin
      set_result(rob_tag_t'(i), DATA_WIDTH'(32'h60 + i), (i == 3), (i == 3) ? 4'h2 : 4'h0);
      next_cycle();
    end
    idle_inputs();
    rif.commit_ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests_run++; if ((rif.commit_o.valid !== 1'b1) || (rif.commit_o.rob_tag !== rob_tag_t'(k)) || (rif.commit_o.exception_valid !== 1'b0)) begin tests_failed++; $display("FAIL exc_pre_commit: got valid=%b tag=%0d exc=%b expected 1/%0d/0", rif.commit_o.valid, rif.commit_o.rob_tag, rif.commit_o.exception_valid, k); end
      next_cycle();
    end
    set_dispatch(3'd6);
    @(negedge clk);
    tests_run++; if ((rif.commit_o.valid !== 1'b1) || (rif.commit_o.rob_tag !== 3'd3) || (rif.commit_o.exception_valid !== 1'b1)) begin tests_failed++; $display("FAIL exc_commit: got valid=%b tag=%0d exc=%b expected 1/3/1", rif.commit_o.valid, rif.commit_o.rob_tag, rif.commit_o.exception_valid); end
    tests_run++; if (rif.commit_o.exception_cause !== 4'h2) begin tests_failed++; $display("FAIL exc_cause: got %h expected 2", rif.commit_o.exception_cause); end
    next_cycle();
    idle_inputs();
    rif.commit_ready_i = 1'b1;
    @(negedge clk);
    tests_run++; if (rif.flush_o !== 1'b1) begin tests_failed++; $display("FAIL exc_flush_pulse: got %b expected 1", rif.flush_o); end
    tests_run++; if (rif.count_o !== 4'd0) begin tests_failed++; $display("FAIL exc_count: got %0d expected 0", rif.count_o); end
    tests_run++; if (rif.alloc_tag_o !== 3'd0) begin tests_failed++; $display("FAIL exc_dispatch_dropped: got %0d expected 0", rif.alloc_tag_o); end
    tests_run++; if (rif.commit_o.valid !== 1'b0) begin tests_failed++; $display("FAIL exc_no_commit4: got %b expected 0", rif.commit_o.valid); end
    next_cycle();
    @(negedge clk);
    tests_run++; if (rif.flush_o !== 1'b0) begin tests_failed++; $display("FAIL exc_flush_once: got %b expected 0", rif.flush_o); end
    tests_run++; if (rif.commit_o.valid !== 1'b0) begin tests_failed++; $display("FAIL exc_no_commit5: got %b expected 0", rif.commit_o.valid); end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_bypass_flush();
    for (int i = 0; i < 6; i++) begin
      set_dispatch(rob_tag_t'(i));
      next_cycle();
    end
    idle_inputs();
    rif.lookup_tag_i[0] = 3'd5;
    rif.lookup_tag_i[1] = 3'd4;
    @(negedge clk);
    tests_run++; if ((rif.lookup_ready_o[0] !== 1'b0) || (rif.lookup_data_o[0] !== '0)) begin tests_failed++; $display("FAIL byp_not_ready: got ready=%b data=%h expected 0/0", rif.lookup_ready_o[0], rif.lookup_data_o[0]); end
    set_result(3'd5, 32'hABCD, 1'b0, '0);
    @(negedge clk);
    tests_run++; if (rif.lookup_ready_o[0] !== 1'b1) begin tests_failed++; $display("FAIL byp_ready: got %b expected 1", rif.lookup_ready_o[0]); end
    tests_run++; if (rif.lookup_data_o[0] !== 32'hABCD) begin tests_failed++; $display("FAIL byp_data: got %h expected abcd", rif.lookup_data_o[0]); end
    tests_run++; if (rif.lookup_ready_o[1] !== 1'b0) begin tests_failed++; $display("FAIL byp_other_port: got %b expected 0", rif.lookup_ready_o[1]); end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    tests_run++; if ((rif.lookup_ready_o[0] !== 1'b1) || (rif.lookup_data_o[0] !== 32'hABCD)) begin tests_failed++; $display("FAIL byp_stored: got ready=%b data=%h expected 1/abcd", rif.lookup_ready_o[0], rif.lookup_data_o[0]); end
    rif.flush_i = 1'b1;
    set_dispatch(3'd6);
    set_result(3'd4, 32'h44, 1'b0, '0);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    tests_run++; if ((rif.lookup_ready_o !== 2'b00) || (rif.lookup_data_o[0] !== '0)) begin tests_failed++; $display("FAIL flush_lookup: got ready=%b data=%h expected 00/0", rif.lookup_ready_o, rif.lookup_data_o[0]); end
    tests_run++; if (rif.alloc_tag_o !== 3'd0) begin tests_failed++; $display("FAIL flush_alloc_tag: got %0d expected 0", rif.alloc_tag_o); end
    tests_run++; if (rif.count_o !== 4'd0) begin tests_failed++; $display("FAIL flush_count: got %0d expected 0", rif.count_o); end
    tests_run++; if (rif.flush_o !== 1'b0) begin tests_failed++; $display("FAIL flush_no_pulse: got %b expected 0", rif.flush_o); end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    set_dispatch(3'd0);
    next_cycle();
    set_dispatch(3'd1);
    next_cycle();
    idle_inputs();
    set_result(3'd0, 32'h99, 1'b0, '0);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    tests_run++; if (rif.commit_o.valid !== 1'b1) begin tests_failed++; $display("FAIL rstmid_pre_valid: got %b expected 1", rif.commit_o.valid); end
    rst = 1'b1;
    rif.commit_ready_i = 1'b1;
    set_dispatch(3'd2);
    @(negedge clk);
    tests_run++; if (rif.commit_o.valid !== 1'b0) begin tests_failed++; $display("FAIL rstmid_commit: got %b expected 0", rif.commit_o.valid); end
    next_cycle();
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    tests_run++; if (rif.count_o !== 4'd0) begin tests_failed++; $display("FAIL rstmid_count: got %0d expected 0", rif.count_o); end
    tests_run++; if (rif.alloc_tag_o !== 3'd0) begin tests_failed++; $display("FAIL rstmid_alloc_tag: got %0d expected 0", rif.alloc_tag_o); end
    tests_run++; if (rif.dispatch_ready_o !== 1'b1) begin tests_failed++; $display("FAIL rstmid_ready: got %b expected 1", rif.dispatch_ready_o); end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_ooo_completion();
    test_backpressure();
    test_wrap();
    test_exception();
    test_bypass_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
